// File: rtl/lr35902_map_pkg.sv
// Shared constants and helpers for the LR35902 memory map and MBC1 bank logic.
package lr35902_map_pkg;

    // CPU-visible region boundaries (inclusive).
    localparam logic [15:0] ROM0_BASE = 16'h0000;
    localparam logic [15:0] ROM0_LAST = 16'h3FFF;
    localparam logic [15:0] ROMX_BASE = 16'h4000;
    localparam logic [15:0] ROMX_LAST = 16'h7FFF;
    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_LAST = 16'h9FFF;
    localparam logic [15:0] XRAM_BASE = 16'hA000;
    localparam logic [15:0] XRAM_LAST = 16'hBFFF;
    localparam logic [15:0] WRAM_BASE = 16'hC000;
    localparam logic [15:0] WRAM_LAST = 16'hDFFF;
    localparam logic [15:0] ECHO_BASE = 16'hE000;
    localparam logic [15:0] ECHO_LAST = 16'hFDFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_LAST  = 16'hFEFF;
    localparam logic [15:0] IO_BASE   = 16'hFF00;
    localparam logic [15:0] IO_LAST   = 16'hFFFF;

    // Mapper control registers living in the IO page.
    localparam logic [15:0] REG_BOOT = 16'hFF50;
    localparam logic [15:0] REG_SVBK = 16'hFF70;

    // Low nibble that enables cartridge RAM.
    localparam logic [3:0] RAM_EN_MAGIC = 4'hA;

    // MBC1 register selected by adr[14:13] of a write into 0x0000-0x7FFF.
    typedef enum logic [1:0] {
        MBC_RAMEN = 2'd0,
        MBC_BANK1 = 2'd1,
        MBC_BANK2 = 2'd2,
        MBC_MODE  = 2'd3
    } mbc_reg_e;

    function automatic logic in_region(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input logic [15:0] last);
        return (a >= base) && (a <= last);
    endfunction

endpackage

// File: rtl/lr35902_mbc1_regs.sv
// MBC1 register file (RAM enable, BANK1, BANK2, mode) and the ROM/XRAM bank
// translation that turns a CPU address into a physical cartridge address.
module lr35902_mbc1_regs
    import lr35902_map_pkg::*;
#(
    parameter int ROM_BANK_W  = 7,
    parameter int XRAM_BANK_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              adr,
    input  logic [4:0]               din,
    input  logic                     wr,
    output logic                     ram_en,
    output logic [ROM_BANK_W+13:0]   rom_adr,
    output logic [XRAM_BANK_W+12:0]  xram_adr
);

    logic       ram_en_q, ram_en_d;
    logic [4:0] bank1_q, bank1_d;
    logic [1:0] bank2_q, bank2_d;
    logic       mode_q, mode_d;

    logic [4:0]  b1eff;
    logic [20:0] rom_full;
    logic [14:0] xram_full;

    // Next-state for the MBC registers: writes anywhere in 0x0000-0x7FFF.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a latch.
        ram_en_d = ram_en_q;
        bank1_d  = bank1_q;
        bank2_d  = bank2_q;
        mode_d   = mode_q;
        if (wr && (in_region(adr, ROM0_BASE, ROM0_LAST) || in_region(adr, ROMX_BASE, ROMX_LAST))) begin
            case (mbc_reg_e'(adr[14:13]))
                MBC_RAMEN: ram_en_d = (din[3:0] == RAM_EN_MAGIC);
                MBC_BANK1: bank1_d  = din[4:0];
                MBC_BANK2: bank2_d  = din[1:0];
                MBC_MODE:  mode_d   = din[0];
            endcase
        end
    end

    // Register update with synchronous active-low reset; reset beats a write.
    always_ff @(posedge clk) begin
        // NOTE: state is only ever assigned with <=; the reset is synchronous, so it is simply the first branch.
        if (!reset) begin
            ram_en_q <= 1'b0;
            bank1_q  <= 5'd0;
            bank2_q  <= 2'd0;
            mode_q   <= 1'b0;
        end else begin
            ram_en_q <= ram_en_d;
            bank1_q  <= bank1_d;
            bank2_q  <= bank2_d;
            mode_q   <= mode_d;
        end
    end

    // Bank translation: build full-width addresses, then drop unused bank bits.
    always_comb begin
        // Only BANK1 == 0 is remapped, so 0x20/0x40/0x60 still land on 0x21/0x41/0x61.
        b1eff = (bank1_q == 5'd0) ? 5'd1 : bank1_q;
        if (adr[14]) begin
            rom_full = {bank2_q, b1eff, adr[13:0]};
        end else if (mode_q) begin
            rom_full = {bank2_q, 5'd0, adr[13:0]};
        end else begin
            rom_full = {7'd0, adr[13:0]};
        end
        xram_full = {(mode_q ? bank2_q : 2'b00), adr[12:0]};
    end

    assign ram_en   = ram_en_q;
    assign rom_adr  = rom_full[ROM_BANK_W+13:0];
    assign xram_adr = xram_full[XRAM_BANK_W+12:0];

endmodule

// File: rtl/lr35902_mbc_map.sv
// LR35902 address map: chip-select decode, boot-ROM disable latch, optional
// CGB WRAM bank register, and the MBC1 bank registers via lr35902_mbc1_regs.
module lr35902_mbc_map
    import lr35902_map_pkg::*;
#(
    parameter int ROM_BANK_W  = 7,
    parameter int XRAM_BANK_W = 2,
    parameter int WRAM_BANK_W = 3,
    parameter int CGB         = 0,
    localparam int WRAM_ADR_W = (CGB != 0) ? WRAM_BANK_W + 12 : 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              adr,
    input  logic [7:0]               din,
    input  logic                     wr,
    output logic                     brom_en,
    output logic                     cs_brom,
    output logic                     cs_rom,
    output logic                     cs_xram,
    output logic                     cs_vram,
    output logic                     cs_wram,
    output logic                     cs_oam,
    output logic                     cs_io,
    output logic [ROM_BANK_W+13:0]   rom_adr,
    output logic [XRAM_BANK_W+12:0]  xram_adr,
    output logic [WRAM_ADR_W-1:0]    wram_adr
);

    localparam int WB_W = WRAM_ADR_W - 12;

    logic            brom_en_q, brom_en_d;
    logic            ram_en;
    logic [WB_W-1:0] wram_bank;

    lr35902_mbc1_regs #(
        .ROM_BANK_W  (ROM_BANK_W),
        .XRAM_BANK_W (XRAM_BANK_W)
    ) u_mbc1_regs (
        .clk      (clk),
        .reset    (reset),
        .adr      (adr),
        .din      (din[4:0]),
        .wr       (wr),
        .ram_en   (ram_en),
        .rom_adr  (rom_adr),
        .xram_adr (xram_adr)
    );

    // Boot latch can only be cleared: a non-zero write to 0xFF50 unmaps the boot ROM.
    always_comb begin
        brom_en_d = brom_en_q;
        if (wr && (adr == REG_BOOT) && (din != 8'h00)) begin
            brom_en_d = 1'b0;
        end
    end

    // Boot latch register; only reset brings the boot ROM back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            brom_en_q <= 1'b1;
        end else begin
            brom_en_q <= brom_en_d;
        end
    end

    assign brom_en = brom_en_q;

    generate
        if (CGB != 0) begin : g_svbk
            logic [WRAM_BANK_W-1:0] wbank_q, wbank_d;

            // SVBK write decode.
            always_comb begin
                wbank_d = wbank_q;
                if (wr && (adr == REG_SVBK)) begin
                    wbank_d = din[WRAM_BANK_W-1:0];
                end
            end

            // SVBK register.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    wbank_q <= '0;
                end else begin
                    wbank_q <= wbank_d;
                end
            end

            // Upper 4k window follows SVBK, with bank 0 aliased to bank 1.
            always_comb begin
                wram_bank = '0;
                if (adr[12]) begin
                    wram_bank = (wbank_q == '0) ? WB_W'(1) : wbank_q;
                end
            end
        end else begin : g_no_svbk
            // DMG: 0xC000 window is bank 0, 0xD000 window is bank 1.
            assign wram_bank = adr[12];
        end
    endgenerate

    // Echo region shares the WRAM translation because only adr[12:0] is used.
    assign wram_adr = {wram_bank, adr[11:0]};

    // Prioritised chip-select decode; everything deselected while reset is held.
    always_comb begin
        cs_brom = 1'b0;
        cs_rom  = 1'b0;
        cs_vram = 1'b0;
        cs_xram = 1'b0;
        cs_oam  = 1'b0;
        cs_io   = 1'b0;
        cs_wram = 1'b0;
        if (reset) begin
            if (brom_en_q && (adr[15:8] == 8'h00)) begin
                cs_brom = 1'b1;
            end else if (in_region(adr, ROM0_BASE, ROM0_LAST) || in_region(adr, ROMX_BASE, ROMX_LAST)) begin
                cs_rom = 1'b1;
            end else if (in_region(adr, VRAM_BASE, VRAM_LAST)) begin
                cs_vram = 1'b1;
            end else if (in_region(adr, XRAM_BASE, XRAM_LAST)) begin
                cs_xram = ram_en;
            end else if (in_region(adr, OAM_BASE, OAM_LAST)) begin
                cs_oam = 1'b1;
            end else if (in_region(adr, IO_BASE, IO_LAST)) begin
                cs_io = 1'b1;
            end else if (in_region(adr, WRAM_BASE, WRAM_LAST) || in_region(adr, ECHO_BASE, ECHO_LAST)) begin
                cs_wram = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lr35902_mbc_map.sv
// Self-checking bench for lr35902_mbc_map. Two instances share one CPU bus:
// dut_a is a CGB build with default widths, dut_b a narrow DMG build.
module tb_lr35902_mbc_map;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        wr;

    logic        a_brom_en, a_brom, a_rom, a_xram, a_vram, a_wram, a_oam, a_io;
    logic [20:0] a_rom_adr;
    logic [14:0] a_xram_adr;
    logic [14:0] a_wram_adr;

    logic        b_brom_en, b_brom, b_rom, b_xram, b_vram, b_wram, b_oam, b_io;
    logic [18:0] b_rom_adr;
    logic [12:0] b_xram_adr;
    logic [12:0] b_wram_adr;

    lr35902_mbc_map #(
        .ROM_BANK_W(7), .XRAM_BANK_W(2), .WRAM_BANK_W(3), .CGB(1)
    ) dut_a (
        .clk(clk), .reset(reset), .adr(adr), .din(din), .wr(wr),
        .brom_en(a_brom_en), .cs_brom(a_brom), .cs_rom(a_rom), .cs_xram(a_xram),
        .cs_vram(a_vram), .cs_wram(a_wram), .cs_oam(a_oam), .cs_io(a_io),
        .rom_adr(a_rom_adr), .xram_adr(a_xram_adr), .wram_adr(a_wram_adr)
    );

    lr35902_mbc_map #(
        .ROM_BANK_W(5), .XRAM_BANK_W(0), .WRAM_BANK_W(3), .CGB(0)
    ) dut_b (
        .clk(clk), .reset(reset), .adr(adr), .din(din), .wr(wr),
        .brom_en(b_brom_en), .cs_brom(b_brom), .cs_rom(b_rom), .cs_xram(b_xram),
        .cs_vram(b_vram), .cs_wram(b_wram), .cs_oam(b_oam), .cs_io(b_io),
        .rom_adr(b_rom_adr), .xram_adr(b_xram_adr), .wram_adr(b_wram_adr)
    );

    always #5 clk = ~clk;

    // Chip-select vector order: {brom, rom, vram, xram, wram, oam, io}.
    localparam logic [31:0] CS_NONE = 32'b0000000;
    localparam logic [31:0] CS_BROM = 32'b1000000;
    localparam logic [31:0] CS_ROM  = 32'b0100000;
    localparam logic [31:0] CS_VRAM = 32'b0010000;
    localparam logic [31:0] CS_XRAM = 32'b0001000;
    localparam logic [31:0] CS_WRAM = 32'b0000100;
    localparam logic [31:0] CS_OAM  = 32'b0000010;
    localparam logic [31:0] CS_IO   = 32'b0000001;

    typedef enum { K_WR, K_RD, K_RST_ON, K_RST_OFF } kind_e;
    typedef enum { S_BROM_EN, S_CS_A, S_ROM_A, S_XRAM_A, S_WRAM_A,
                   S_BROM_EN_B, S_CS_B, S_ROM_B, S_XRAM_B, S_WRAM_B } sig_e;

    typedef struct {
        kind_e       kind;
        logic [15:0] adr;
        logic [7:0]  din;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } step_t;

    step_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_BROM_EN:   return {31'd0, a_brom_en};
            S_CS_A:      return {25'd0, a_brom, a_rom, a_vram, a_xram, a_wram, a_oam, a_io};
            S_ROM_A:     return {11'd0, a_rom_adr};
            S_XRAM_A:    return {17'd0, a_xram_adr};
            S_WRAM_A:    return {17'd0, a_wram_adr};
            S_BROM_EN_B: return {31'd0, b_brom_en};
            S_CS_B:      return {25'd0, b_brom, b_rom, b_vram, b_xram, b_wram, b_oam, b_io};
            S_ROM_B:     return {13'd0, b_rom_adr};
            S_XRAM_B:    return {19'd0, b_xram_adr};
            S_WRAM_B:    return {19'd0, b_wram_adr};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Bus driver: inputs change 1 time unit after a rising edge; a read step
    // returns at the following falling edge, where outputs are sampled.
    task automatic drive_step(input step_t s);
        case (s.kind)
            K_WR: begin
                adr = s.adr; din = s.din; wr = 1'b1;
                @(posedge clk); #1 wr = 1'b0;
            end
            K_RST_ON: begin
                reset = 1'b0; adr = s.adr; din = s.din; wr = 1'b1;
                @(posedge clk); #1 wr = 1'b0;
            end
            K_RST_OFF: begin
                reset = 1'b1;
                @(posedge clk); #1;
            end
            K_RD: begin
                adr = s.adr; din = 8'h00;
                @(negedge clk);
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_RST_ON,  16'h3000, 8'h00, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RST_ON,  16'h3000, 8'h00, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RD,      16'h0042, 8'h00, S_CS_A,    CS_NONE,  "rst cs_a idle"});
        st.push_back(step_t'{K_RD,      16'hC000, 8'h00, S_CS_B,    CS_NONE,  "rst cs_b idle"});
        st.push_back(step_t'{K_RD,      16'h0000, 8'h00, S_BROM_EN, 1,        "rst brom_en"});
        st.push_back(step_t'{K_RST_OFF, 16'h0000, 8'h00, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RD,      16'h0042, 8'h00, S_CS_A,    CS_BROM,  "boot cs_a 0042"});
        st.push_back(step_t'{K_RD,      16'h0042, 8'h00, S_CS_B,    CS_BROM,  "boot cs_b 0042"});
        st.push_back(step_t'{K_RD,      16'h00FF, 8'h00, S_CS_A,    CS_BROM,  "boot cs 00ff"});
        st.push_back(step_t'{K_RD,      16'h0100, 8'h00, S_CS_A,    CS_ROM,   "boot cs 0100"});
        st.push_back(step_t'{K_RD,      16'h0100, 8'h00, S_ROM_A,   32'h0100, "boot rom_adr 0100"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_boot_latch();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_WR, 16'hFF50, 8'h00, S_CS_A,      0,       "-"});
        st.push_back(step_t'{K_RD, 16'h0042, 8'h00, S_BROM_EN,   1,       "ff50<=0 keeps brom"});
        st.push_back(step_t'{K_RD, 16'h0042, 8'h00, S_CS_A,      CS_BROM, "ff50<=0 cs brom"});
        st.push_back(step_t'{K_WR, 16'hFF50, 8'h01, S_CS_A,      0,       "-"});
        st.push_back(step_t'{K_RD, 16'h0042, 8'h00, S_CS_A,      CS_ROM,  "unmapped cs rom"});
        st.push_back(step_t'{K_RD, 16'h0042, 8'h00, S_ROM_A,     32'h42,  "unmapped rom_adr"});
        st.push_back(step_t'{K_RD, 16'h0042, 8'h00, S_BROM_EN,   0,       "brom_en cleared"});
        st.push_back(step_t'{K_RD, 16'h0042, 8'h00, S_BROM_EN_B, 0,       "brom_en_b cleared"});
        st.push_back(step_t'{K_WR, 16'hFF50, 8'h00, S_CS_A,      0,       "-"});
        st.push_back(step_t'{K_RD, 16'h0000, 8'h00, S_BROM_EN,   0,       "brom never re-enables"});
        st.push_back(step_t'{K_RD, 16'h0000, 8'h00, S_CS_B,      CS_ROM,  "cs_b rom 0000"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_rom_bank();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_WR, 16'h2000, 8'h00, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_RD, 16'h4123, 8'h00, S_ROM_A, 32'h04123,   "bank1=0 maps to 1"});
        st.push_back(step_t'{K_RD, 16'h4123, 8'h00, S_CS_A,  CS_ROM,      "romx cs"});
        st.push_back(step_t'{K_WR, 16'h2000, 8'h13, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_WR, 16'h4000, 8'h02, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_RD, 16'h4123, 8'h00, S_ROM_A, 32'h14C123,  "bank 0x53"});
        st.push_back(step_t'{K_RD, 16'h4123, 8'h00, S_ROM_B, 32'h4C123,   "bank 0x53 trunc5"});
        st.push_back(step_t'{K_RD, 16'h3FFF, 8'h00, S_ROM_A, 32'h03FFF,   "rom0 mode0 top"});
        st.push_back(step_t'{K_RD, 16'h7FFF, 8'h00, S_ROM_A, 32'h14FFFF,  "romx top"});
        st.push_back(step_t'{K_WR, 16'h2000, 8'h20, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_RD, 16'h4000, 8'h00, S_ROM_A, 32'h104000,  "bank 0x40 to 0x41"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_xram_mode();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_WR, 16'h6000, 8'h01, S_CS_A,   0,          "-"});
        st.push_back(step_t'{K_WR, 16'h4000, 8'h03, S_CS_A,   0,          "-"});
        st.push_back(step_t'{K_RD, 16'h0010, 8'h00, S_ROM_A,  32'h180010, "mode1 rom0 bank 0x60"});
        st.push_back(step_t'{K_RD, 16'h0010, 8'h00, S_ROM_B,  32'h00010,  "mode1 rom0 trunc5"});
        st.push_back(step_t'{K_RD, 16'h4000, 8'h00, S_ROM_A,  32'h184000, "mode1 romx bank 0x61"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_CS_A,   CS_NONE,    "xram disabled"});
        st.push_back(step_t'{K_WR, 16'h0000, 8'h0A, S_CS_A,   0,          "-"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_CS_A,   CS_XRAM,    "xram enabled"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_XRAM_A, 32'h6005,   "xram bank3"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_XRAM_B, 32'h0005,   "xram single bank"});
        st.push_back(step_t'{K_RD, 16'hBFFF, 8'h00, S_XRAM_A, 32'h7FFF,   "xram top"});
        st.push_back(step_t'{K_WR, 16'h6000, 8'h00, S_CS_A,   0,          "-"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_XRAM_A, 32'h0005,   "xram mode0 bank0"});
        st.push_back(step_t'{K_RD, 16'h0010, 8'h00, S_ROM_A,  32'h00010,  "mode0 rom0"});
        st.push_back(step_t'{K_WR, 16'h1FFF, 8'h1B, S_CS_A,   0,          "-"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_CS_A,   CS_NONE,    "xram re-disabled"});
        st.push_back(step_t'{K_WR, 16'h0000, 8'h3A, S_CS_A,   0,          "-"});
        st.push_back(step_t'{K_RD, 16'hA005, 8'h00, S_CS_B,   CS_XRAM,    "xram low nibble A"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_wram_map();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_WR, 16'hFF70, 8'h00, S_CS_A,   0,       "-"});
        st.push_back(step_t'{K_RD, 16'hD010, 8'h00, S_WRAM_A, 32'h1010, "svbk0 maps to 1"});
        st.push_back(step_t'{K_RD, 16'hD010, 8'h00, S_CS_A,   CS_WRAM, "wram cs"});
        st.push_back(step_t'{K_RD, 16'hC010, 8'h00, S_WRAM_A, 32'h0010, "wram bank0 window"});
        st.push_back(step_t'{K_WR, 16'hFF70, 8'h05, S_CS_A,   0,       "-"});
        st.push_back(step_t'{K_RD, 16'hD010, 8'h00, S_WRAM_A, 32'h5010, "svbk5"});
        st.push_back(step_t'{K_RD, 16'hF010, 8'h00, S_WRAM_A, 32'h5010, "echo svbk5"});
        st.push_back(step_t'{K_RD, 16'hF010, 8'h00, S_CS_A,   CS_WRAM, "echo cs"});
        st.push_back(step_t'{K_RD, 16'hD010, 8'h00, S_WRAM_B, 32'h1010, "dmg ignores svbk"});
        st.push_back(step_t'{K_RD, 16'hE010, 8'h00, S_WRAM_B, 32'h0010, "dmg echo bank0"});
        st.push_back(step_t'{K_RD, 16'hFDFF, 8'h00, S_CS_A,   CS_WRAM, "echo top cs"});
        st.push_back(step_t'{K_RD, 16'hFE10, 8'h00, S_CS_A,   CS_OAM,  "oam cs"});
        st.push_back(step_t'{K_RD, 16'hFF80, 8'h00, S_CS_A,   CS_IO,   "io cs"});
        st.push_back(step_t'{K_RD, 16'h8000, 8'h00, S_CS_A,   CS_VRAM, "vram cs low"});
        st.push_back(step_t'{K_RD, 16'h9FFF, 8'h00, S_CS_B,   CS_VRAM, "vram cs high"});
        st.push_back(step_t'{K_WR, 16'hFF70, 8'h0F, S_CS_A,   0,       "-"});
        st.push_back(step_t'{K_RD, 16'hD000, 8'h00, S_WRAM_A, 32'h7000, "svbk uses low 3 bits"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_beats_write();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_WR,      16'h2000, 8'h05, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RST_ON,  16'h2000, 8'h1F, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RD,      16'h0042, 8'h00, S_CS_A,    CS_NONE,  "in reset cs_a"});
        st.push_back(step_t'{K_RD,      16'hFE10, 8'h00, S_CS_B,    CS_NONE,  "in reset cs_b"});
        st.push_back(step_t'{K_RD,      16'h4000, 8'h00, S_BROM_EN, 1,        "in reset brom_en"});
        st.push_back(step_t'{K_RST_ON,  16'h2000, 8'h1F, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RST_OFF, 16'h0000, 8'h00, S_CS_A,    0,        "-"});
        st.push_back(step_t'{K_RD,      16'h4000, 8'h00, S_ROM_A,   32'h4000, "bank1 held in reset"});
        st.push_back(step_t'{K_RD,      16'h0042, 8'h00, S_CS_A,    CS_BROM,  "brom back after reset"});
        st.push_back(step_t'{K_RD,      16'hA005, 8'h00, S_CS_A,    CS_NONE,  "ram_en cleared"});
        st.push_back(step_t'{K_RD,      16'hD010, 8'h00, S_WRAM_A,  32'h1010, "svbk cleared"});
        st.push_back(step_t'{K_RD,      16'h0150, 8'h00, S_ROM_A,   32'h0150, "mode cleared"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_rom_truncate();
        step_t st[$];
        step_t e;
        logic [31:0] obs;
        st.push_back(step_t'{K_WR, 16'hFF50, 8'h01, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_WR, 16'h4000, 8'h03, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_WR, 16'h2000, 8'h07, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_RD, 16'h4000, 8'h00, S_ROM_B, 32'h1C000,   "trunc5 bank 0x67"});
        st.push_back(step_t'{K_RD, 16'h4000, 8'h00, S_ROM_A, 32'h19C000,  "full bank 0x67"});
        st.push_back(step_t'{K_WR, 16'h2000, 8'h00, S_CS_A,  0,           "-"});
        st.push_back(step_t'{K_RD, 16'h4000, 8'h00, S_ROM_B, 32'h04000,   "trunc5 bank 0x61"});
        st.push_back(step_t'{K_RD, 16'h7FFF, 8'h00, S_ROM_B, 32'h07FFF,   "trunc5 romx top"});
        foreach (st[i]) begin
            if (st[i].kind == K_RD) sb.push_back(st[i]);
            drive_step(st[i]);
            if (st[i].kind == K_RD) begin
                e = sb.pop_front(); obs = observe(e.sig); n_checks++;
                if (obs !== e.exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, obs, e.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        adr   = 16'h0000;
        din   = 8'h00;
        wr    = 1'b0;
        test_reset();
        test_boot_latch();
        test_rom_bank();
        test_xram_mode();
        test_wram_map();
        test_reset_beats_write();
        test_rom_truncate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
